// File: rtl/sigma_xbus_arbiter.sv
// Two-master round-robin arbiter for the sigma shared bus, one outstanding transaction at a time.
// Optional read-response watchdog enabled by defining ARB_WATCHDOG_EN.
module sigma_xbus_arbiter #(
  parameter int unsigned ADDR_WIDTH     = 32,
  parameter int unsigned DATA_WIDTH     = 32,
  parameter int unsigned TIMEOUT_CYCLES = 1024
) (
  input  logic                    clk_i,
  input  logic                    arst_n_i,
  input  logic                    m0_req_i,
  input  logic                    m0_we_i,
  input  logic [ADDR_WIDTH-1:0]   m0_addr_i,
  input  logic [DATA_WIDTH/8-1:0] m0_be_i,
  input  logic [DATA_WIDTH-1:0]   m0_wdata_i,
  output logic                    m0_ack_o,
  output logic                    m0_resp_o,
  output logic [DATA_WIDTH-1:0]   m0_rdata_o,
  input  logic                    m1_req_i,
  input  logic                    m1_we_i,
  input  logic [ADDR_WIDTH-1:0]   m1_addr_i,
  input  logic [DATA_WIDTH/8-1:0] m1_be_i,
  input  logic [DATA_WIDTH-1:0]   m1_wdata_i,
  output logic                    m1_ack_o,
  output logic                    m1_resp_o,
  output logic [DATA_WIDTH-1:0]   m1_rdata_o,
  output logic                    s_req_o,
  output logic                    s_we_o,
  output logic [ADDR_WIDTH-1:0]   s_addr_o,
  output logic [DATA_WIDTH/8-1:0] s_be_o,
  output logic [DATA_WIDTH-1:0]   s_wdata_o,
  input  logic                    s_ack_i,
  input  logic                    s_resp_i,
  input  logic [DATA_WIDTH-1:0]   s_rdata_i,
  output logic [1:0]              grant_o,
  output logic                    err_o
);

  typedef enum logic [1:0] {StIdle, StCmd, StResp} state_e;

  state_e                state_q, state_d;
  logic [1:0]            grant_q, grant_d;
  logic                  last_q, last_d;  // 1: master 1 was served last
  logic [DATA_WIDTH-1:0] rdata0_q, rdata0_d, rdata1_q, rdata1_d;
  logic                  timeout;
  logic                  done;
  logic [DATA_WIDTH-1:0] resp_data;

`ifdef ARB_WATCHDOG_EN
  localparam int unsigned CntW = $clog2(TIMEOUT_CYCLES + 1);
  logic [CntW-1:0] wd_cnt_q, wd_cnt_d;

  // Counter sits at 0 outside RESP, so it is cleared on every entry.
  assign wd_cnt_d = (state_q == StResp) ? wd_cnt_q + 1'b1 : '0;
  assign timeout  = (state_q == StResp) && (wd_cnt_q == CntW'(TIMEOUT_CYCLES - 1));
  assign err_o    = timeout & ~s_resp_i;

  always_ff @(posedge clk_i or negedge arst_n_i) begin
    if (!arst_n_i) begin
      wd_cnt_q <= '0;
    end else begin
      wd_cnt_q <= wd_cnt_d;
    end
  end
`else
  logic unused_timeout;
  assign unused_timeout = ^TIMEOUT_CYCLES;
  assign timeout        = 1'b0;
  assign err_o          = 1'b0;
`endif

  assign done      = (state_q == StResp) && (s_resp_i || timeout);
  assign resp_data = s_resp_i ? s_rdata_i : DATA_WIDTH'(32'hDEAD_BEEF);

  always_comb begin
    state_d  = state_q;
    grant_d  = grant_q;
    last_d   = last_q;
    rdata0_d = rdata0_q;
    rdata1_d = rdata1_q;
    unique case (state_q)
      StIdle: begin
        if (m0_req_i && m1_req_i) begin
          grant_d = last_q ? 2'b01 : 2'b10;
          state_d = StCmd;
        end else if (m0_req_i) begin
          grant_d = 2'b01;
          state_d = StCmd;
        end else if (m1_req_i) begin
          grant_d = 2'b10;
          state_d = StCmd;
        end
      end
      StCmd: begin
        if (s_ack_i) begin
          if (s_we_o) begin
            last_d  = grant_q[1];
            grant_d = 2'b00;
            state_d = StIdle;
          end else begin
            state_d = StResp;
          end
        end
      end
      StResp: begin
        if (done) begin
          if (grant_q[0]) rdata0_d = resp_data;
          if (grant_q[1]) rdata1_d = resp_data;
          last_d  = grant_q[1];
          grant_d = 2'b00;
          state_d = StIdle;
        end
      end
      default: begin
        grant_d = 2'b00;
        state_d = StIdle;
      end
    endcase
  end

  always_comb begin
    s_req_o   = (state_q == StCmd);
    s_we_o    = 1'b0;
    s_addr_o  = '0;
    s_be_o    = '0;
    s_wdata_o = '0;
    if (s_req_o && grant_q[0]) begin
      s_we_o    = m0_we_i;
      s_addr_o  = m0_addr_i;
      s_be_o    = m0_be_i;
      s_wdata_o = m0_wdata_i;
    end else if (s_req_o && grant_q[1]) begin
      s_we_o    = m1_we_i;
      s_addr_o  = m1_addr_i;
      s_be_o    = m1_be_i;
      s_wdata_o = m1_wdata_i;
    end
  end

  assign m0_ack_o   = s_req_o && s_ack_i && grant_q[0];
  assign m1_ack_o   = s_req_o && s_ack_i && grant_q[1];
  assign m0_resp_o  = done && grant_q[0];
  assign m1_resp_o  = done && grant_q[1];
  assign m0_rdata_o = rdata0_d;
  assign m1_rdata_o = rdata1_d;
  assign grant_o    = grant_q;

  always_ff @(posedge clk_i or negedge arst_n_i) begin
    if (!arst_n_i) begin
      state_q  <= StIdle;
      grant_q  <= 2'b00;
      last_q   <= 1'b1;
      rdata0_q <= '0;
      rdata1_q <= '0;
    end else begin
      state_q  <= state_d;
      grant_q  <= grant_d;
      last_q   <= last_d;
      rdata0_q <= rdata0_d;
      rdata1_q <= rdata1_d;
    end
  end

endmodule

// File: tb/tb_sigma_xbus_arbiter.sv
// Self-checking bench for sigma_xbus_arbiter: transaction table plus hand-written corner sequences,
// with a scoreboard of expected ack/resp pulses.
module tb_sigma_xbus_arbiter;

  logic        clk_i = 1'b0;
  logic        arst_n_i = 1'b0;
  logic        m0_req_i = 0, m0_we_i = 0, m1_req_i = 0, m1_we_i = 0;
  logic [31:0] m0_addr_i = 0, m0_wdata_i = 0, m1_addr_i = 0, m1_wdata_i = 0;
  logic [3:0]  m0_be_i = 0, m1_be_i = 0;
  logic        m0_ack_o, m0_resp_o, m1_ack_o, m1_resp_o;
  logic [31:0] m0_rdata_o, m1_rdata_o;
  logic        s_req_o, s_we_o;
  logic [31:0] s_addr_o, s_wdata_o;
  logic [3:0]  s_be_o;
  logic        s_ack_i = 0, s_resp_i = 0;
  logic [31:0] s_rdata_i = 0;
  logic [1:0]  grant_o;
  logic        err_o;

  sigma_xbus_arbiter #(
    .ADDR_WIDTH     (32),
    .DATA_WIDTH     (32),
    .TIMEOUT_CYCLES (16)
  ) dut (
    .clk_i      (clk_i),
    .arst_n_i   (arst_n_i),
    .m0_req_i   (m0_req_i),
    .m0_we_i    (m0_we_i),
    .m0_addr_i  (m0_addr_i),
    .m0_be_i    (m0_be_i),
    .m0_wdata_i (m0_wdata_i),
    .m0_ack_o   (m0_ack_o),
    .m0_resp_o  (m0_resp_o),
    .m0_rdata_o (m0_rdata_o),
    .m1_req_i   (m1_req_i),
    .m1_we_i    (m1_we_i),
    .m1_addr_i  (m1_addr_i),
    .m1_be_i    (m1_be_i),
    .m1_wdata_i (m1_wdata_i),
    .m1_ack_o   (m1_ack_o),
    .m1_resp_o  (m1_resp_o),
    .m1_rdata_o (m1_rdata_o),
    .s_req_o    (s_req_o),
    .s_we_o     (s_we_o),
    .s_addr_o   (s_addr_o),
    .s_be_o     (s_be_o),
    .s_wdata_o  (s_wdata_o),
    .s_ack_i    (s_ack_i),
    .s_resp_i   (s_resp_i),
    .s_rdata_i  (s_rdata_i),
    .grant_o    (grant_o),
    .err_o      (err_o)
  );

  always #5 clk_i = ~clk_i;

  int checks = 0;
  int errors = 0;

  typedef struct {
    logic        is_resp;
    logic        mst;
    logic [31:0] rdata;
  } ev_t;
  ev_t sb_q[$];

  typedef struct {
    logic        mst;
    logic        we;
    logic [31:0] addr;
    logic [3:0]  be;
    logic [31:0] wdata;
    int          ack_wait;
    int          resp_wait;
    logic [31:0] rdata;
    logic [1:0]  exp_grant;
  } vec_t;

  logic [31:0] exp_rd [2];

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic sb_pop(input logic is_resp, input logic mst, input logic [31:0] rdata);
    ev_t e;
    checks++;
    if (sb_q.size() == 0) begin
      errors++;
      $display("FAIL sb_unexpected: got %s on m%0d, expected no event at %0t",
               is_resp ? "resp" : "ack", mst, $time);
    end else begin
      e = sb_q.pop_front();
      if (e.is_resp !== is_resp || e.mst !== mst || (is_resp && e.rdata !== rdata)) begin
        errors++;
        $display("FAIL sb_event: got resp=%0b m%0d data=%0h expected resp=%0b m%0d data=%0h",
                 is_resp, mst, rdata, e.is_resp, e.mst, e.rdata);
      end
    end
  endtask

  task automatic sb_push(input logic is_resp, input logic mst, input logic [31:0] rdata);
    ev_t e;
    e.is_resp = is_resp;
    e.mst     = mst;
    e.rdata   = rdata;
    sb_q.push_back(e);
  endtask

  always @(negedge clk_i) begin
    if (m0_ack_o)  sb_pop(1'b0, 1'b0, 32'h0);
    if (m1_ack_o)  sb_pop(1'b0, 1'b1, 32'h0);
    if (m0_resp_o) sb_pop(1'b1, 1'b0, m0_rdata_o);
    if (m1_resp_o) sb_pop(1'b1, 1'b1, m1_rdata_o);
  end

  task automatic set_master(input logic mst, input logic req, input logic we,
                            input logic [31:0] addr, input logic [3:0] be,
                            input logic [31:0] wdata);
    if (!mst) begin
      m0_req_i = req; m0_we_i = we; m0_addr_i = addr; m0_be_i = be; m0_wdata_i = wdata;
    end else begin
      m1_req_i = req; m1_we_i = we; m1_addr_i = addr; m1_be_i = be; m1_wdata_i = wdata;
    end
  endtask

  task automatic do_reset();
    arst_n_i = 1'b0;
    #1;
    chk("rst_outputs", {s_req_o, s_we_o, s_addr_o, s_be_o, s_wdata_o, grant_o, err_o,
                        m0_ack_o, m0_resp_o, m1_ack_o, m1_resp_o}, '0);
    chk("rst_rdata", {m0_rdata_o, m1_rdata_o}, '0);
    repeat (2) @(posedge clk_i);
    #1 arst_n_i = 1'b1;
    exp_rd[0] = '0;
    exp_rd[1] = '0;
  endtask

  task automatic do_txn(input vec_t v);
    @(posedge clk_i) #1;
    set_master(v.mst, 1'b1, v.we, v.addr, v.be, v.wdata);
    @(negedge clk_i);
    chk("idle_s_req", s_req_o, 1'b0);
    chk("idle_grant", grant_o, 2'b00);
    @(posedge clk_i) #1;
    for (int i = 0; i <= v.ack_wait; i++) begin
      if (i == v.ack_wait) begin
        s_ack_i = 1'b1;
        sb_push(1'b0, v.mst, 32'h0);
      end
      @(negedge clk_i);
      chk("cmd_s_req", s_req_o, 1'b1);
      chk("cmd_fields", {s_we_o, s_addr_o, s_be_o, s_wdata_o}, {v.we, v.addr, v.be, v.wdata});
      chk("cmd_grant", grant_o, v.exp_grant);
      @(posedge clk_i) #1;
    end
    s_ack_i = 1'b0;
    set_master(v.mst, 1'b0, 1'b0, 32'h0, 4'h0, 32'h0);
    if (!v.we) begin
      for (int i = 0; i <= v.resp_wait; i++) begin
        if (i == v.resp_wait) begin
          s_resp_i  = 1'b1;
          s_rdata_i = v.rdata;
          sb_push(1'b1, v.mst, v.rdata);
          exp_rd[v.mst] = v.rdata;
        end else begin
          s_rdata_i = ~v.rdata;
        end
        @(negedge clk_i);
        chk("resp_s_req", s_req_o, 1'b0);
        chk("resp_grant", grant_o, v.exp_grant);
        @(posedge clk_i) #1;
      end
      s_resp_i  = 1'b0;
      s_rdata_i = 32'h0;
    end
    @(negedge clk_i);
    chk("done_grant", grant_o, 2'b00);
    chk("done_rdata0", m0_rdata_o, exp_rd[0]);
    chk("done_rdata1", m1_rdata_o, exp_rd[1]);
  endtask

  task automatic tie_check(input logic [1:0] exp);
    @(posedge clk_i) #1;
    set_master(1'b0, 1'b1, 1'b1, 32'h0000_0100, 4'hF, 32'h0);
    set_master(1'b1, 1'b1, 1'b1, 32'h0000_0200, 4'hF, 32'h0);
    s_ack_i = 1'b1;
    sb_push(1'b0, exp[1], 32'h0);
    @(negedge clk_i);
    chk("tie_idle_grant", grant_o, 2'b00);
    @(negedge clk_i);
    chk("tie_grant", grant_o, exp);
    @(posedge clk_i) #1;
    set_master(1'b0, 1'b0, 1'b0, 32'h0, 4'h0, 32'h0);
    set_master(1'b1, 1'b0, 1'b0, 32'h0, 4'h0, 32'h0);
    s_ack_i = 1'b0;
  endtask

  vec_t vecs [5];

  initial begin
    vecs[0] = '{1'b0, 1'b1, 32'h8000_0000, 4'hF, 32'hDEAD_BEEF, 0, 0, 32'h0, 2'b01};
    vecs[1] = '{1'b1, 1'b0, 32'h8000_0004, 4'hF, 32'h0, 0, 3, 32'h0000_0030, 2'b10};
    vecs[2] = '{1'b0, 1'b1, 32'h0000_0010, 4'h3, 32'h1234_5678, 5, 0, 32'h0, 2'b01};
    vecs[3] = '{1'b0, 1'b0, 32'h0000_0010, 4'hF, 32'h0, 1, 0, 32'hCAFE_F00D, 2'b01};
    vecs[4] = '{1'b1, 1'b1, 32'h8000_0008, 4'h8, 32'hA5A5_5A5A, 2, 0, 32'h0, 2'b10};

    do_reset();
    for (int n = 0; n < 5; n++) do_txn(vecs[n]);

    // Continuous writes from both masters must alternate starting with m0.
    do_reset();
    @(posedge clk_i) #1;
    set_master(1'b0, 1'b1, 1'b1, 32'h0000_0040, 4'hF, 32'h1);
    set_master(1'b1, 1'b1, 1'b1, 32'h8000_0040, 4'hF, 32'h2);
    s_ack_i = 1'b1;
    for (int k = 0; k < 4; k++) sb_push(1'b0, k[0], 32'h0);
    for (int k = 0; k < 4; k++) begin
      @(negedge clk_i);
      chk("rr_idle_grant", grant_o, 2'b00);
      @(negedge clk_i);
      chk("rr_grant", grant_o, k[0] ? 2'b10 : 2'b01);
      chk("rr_addr", s_addr_o, k[0] ? 32'h8000_0040 : 32'h0000_0040);
    end
    @(posedge clk_i) #1;
    set_master(1'b0, 1'b0, 1'b0, 32'h0, 4'h0, 32'h0);
    set_master(1'b1, 1'b0, 1'b0, 32'h0, 4'h0, 32'h0);
    s_ack_i = 1'b0;

    // Reset while an m0 read waits in RESP; a late response must be dropped.
    do_reset();
    @(posedge clk_i) #1;
    set_master(1'b0, 1'b1, 1'b0, 32'h0000_0020, 4'hF, 32'h0);
    @(posedge clk_i) #1;
    s_ack_i = 1'b1;
    sb_push(1'b0, 1'b0, 32'h0);
    @(posedge clk_i) #1;
    s_ack_i = 1'b0;
    set_master(1'b0, 1'b0, 1'b0, 32'h0, 4'h0, 32'h0);
    @(negedge clk_i);
    chk("mid_resp_grant", grant_o, 2'b01);
    #2 arst_n_i = 1'b0;
    #1;
    chk("mid_rst_s_req", s_req_o, 1'b0);
    chk("mid_rst_grant", grant_o, 2'b00);
    @(posedge clk_i) #1;
    arst_n_i  = 1'b1;
    s_resp_i  = 1'b1;
    s_rdata_i = 32'h1111_2222;
    @(negedge clk_i);
    chk("late_resp", m0_resp_o, 1'b0);
    chk("late_rdata", m0_rdata_o, 32'h0);
    chk("late_grant", grant_o, 2'b00);
    @(posedge clk_i) #1;
    s_resp_i  = 1'b0;
    s_rdata_i = 32'h0;
    tie_check(2'b01);
    tie_check(2'b10);

`ifdef ARB_WATCHDOG_EN
    do_reset();
    @(posedge clk_i) #1;
    set_master(1'b0, 1'b1, 1'b0, 32'h0000_0030, 4'hF, 32'h0);
    @(posedge clk_i) #1;
    s_ack_i = 1'b1;
    sb_push(1'b0, 1'b0, 32'h0);
    @(posedge clk_i) #1;
    s_ack_i = 1'b0;
    set_master(1'b0, 1'b0, 1'b0, 32'h0, 4'h0, 32'h0);
    for (int i = 1; i <= 16; i++) begin
      if (i == 16) sb_push(1'b1, 1'b0, 32'hDEAD_BEEF);
      @(negedge clk_i);
      chk("wd_err", err_o, i == 16);
      @(posedge clk_i) #1;
    end
    @(negedge clk_i);
    chk("wd_rdata_hold", m0_rdata_o, 32'hDEAD_BEEF);
    chk("wd_err_clear", err_o, 1'b0);
    tie_check(2'b10);
`endif

    repeat (3) @(posedge clk_i);
    chk("sb_drain", sb_q.size(), 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: simulation did not finish, limit 200000 reached");
    $fatal(1);
  end

endmodule

// File: doc/sigma_xbus_arbiter.md
Name: sigma_xbus_arbiter

Overview:
- Two-master, one-slave arbiter on the sigma SoC's shared memory/CSR bus.
- Master 0 is the CPU data port. Master 1 is the UDM debug master.
- The slave side drives the RAM/CSR interconnect (RAM at 0x00000000, CSRs at 0x80000000).
- Grants are round-robin with one outstanding transaction, so UDM accesses (e.g. wr32 to the LED CSR) can interleave safely with running firmware.

Parameters:
- ADDR_WIDTH, 32, address width of all ports.
- DATA_WIDTH, 32, data width; byte-enable width is DATA_WIDTH/8.
- TIMEOUT_CYCLES, 1024, read-response watchdog limit; used only with ARB_WATCHDOG_EN.

Ports:
- clk_i  in  1  system clock.
- arst_n_i  in  1  asynchronous reset, active-low.
- mN_req_i  in  1  master N request (N = 0, 1), held until mN_ack_o.
- mN_we_i  in  1  master N write (1) / read (0).
- mN_addr_i  in  ADDR_WIDTH  master N address.
- mN_be_i  in  DATA_WIDTH/8  master N byte enables.
- mN_wdata_i  in  DATA_WIDTH  master N write data.
- mN_ack_o  out  1  master N request accepted (1-cycle pulse).
- mN_resp_o  out  1  master N read data valid (1-cycle pulse).
- mN_rdata_o  out  DATA_WIDTH  master N read data.
- s_req_o  out  1  slave request.
- s_we_o, s_addr_o, s_be_o, s_wdata_o  out  as master  slave command fields.
- s_ack_i  in  1  slave accepted request.
- s_resp_i  in  1  slave read data valid.
- s_rdata_i  in  DATA_WIDTH  slave read data.
- grant_o  out  2  one-hot current owner; 0 when idle.
- err_o  out  1  watchdog timeout pulse; tied 0 without ARB_WATCHDOG_EN.

Behaviour:
- Reset values: every output is 0; state = IDLE; last_grant = 1, so master 0 wins the first tie.
- IDLE:
  - No req: stay in IDLE.
  - Exactly one req: grant that master.
  - Both req: grant the master != last_grant.
  - On grant, register grant_q, set grant_o, go to CMD. There is 1 cycle of arbitration latency; nothing is driven on the slave side in IDLE.
- CMD:
  - s_req_o = 1. s_we/addr/be/wdata are muxed from the granted master's live inputs; the master holds them stable per protocol.
  - On s_ack_i, assert the granted mN_ack_o in the same cycle (combinational from s_ack_i and grant_q).
  - Write: last_grant <= grant_q, go to IDLE.
  - Read: go to RESP.
  - If the granted master drops req before ack (protocol violation), hold s_req_o anyway until ack.
- RESP:
  - s_req_o = 0.
  - On s_resp_i, pulse the granted mN_resp_o in the same cycle with mN_rdata_o = s_rdata_i, set last_grant <= grant_q, go to IDLE.
  - The non-granted master's ack, resp and rdata stay 0.
- Throughput: a write takes at least 2 cycles (IDLE, CMD with ack). A read takes at least 3 cycles (IDLE, CMD, RESP with resp).
- Stray inputs: s_resp_i in IDLE or CMD is ignored and dropped. s_ack_i outside CMD is ignored.
- Simultaneous events: a new request arriving in the same cycle as completion is evaluated in the next IDLE cycle, using the updated last_grant.
- Reset mid-transaction: s_req_o and grant_o drop asynchronously and the state returns to IDLE. A late s_resp_i after reset is dropped.
- mN_rdata_o holds its last value between resp pulses; it is 0 after reset.

Optional Feature:
- Macro ARB_WATCHDOG_EN.
- Defined:
  - A counter clears on entry to RESP and increments each RESP cycle.
  - If it reaches TIMEOUT_CYCLES with no s_resp_i, pulse the granted mN_resp_o with rdata = 0xDEADBEEF, pulse err_o for 1 cycle, update last_grant, and go to IDLE.
  - s_resp_i arriving in the same cycle as the timeout takes precedence: normal response, no err_o.
- Undefined: no counter is built, err_o = 0, and RESP waits indefinitely.

Test Plan:
- Reset, then m0 writes 0xDEADBEEF to 0x80000000 with be = 0xF and the slave acks immediately -> s_req_o high 1 cycle later with matching fields; m0_ack_o pulses once; grant_o = 01 during CMD, then 00; m1 outputs stay 0.
- m1 reads 0x80000004, slave acks, then asserts s_resp_i with 0x00000030 after 3 cycles -> m1_resp_o is a single pulse with m1_rdata_o = 0x30; m0_resp_o stays 0.
- Both masters hold continuous write requests -> grants alternate m0, m1, m0, m1 after reset; no master is granted twice in a row while the other is waiting.
- Assert arst_n_i low in RESP during an m0 read, release it, and have the slave then assert s_resp_i -> m0_resp_o never pulses; state is IDLE; the next tie grants m0.
- With ARB_WATCHDOG_EN and TIMEOUT_CYCLES = 16, the slave never responds -> after 16 RESP cycles m0_resp_o pulses with 0xDEADBEEF and err_o pulses once; the next tie is granted to m1.
- Slave holds s_ack_i low for 5 cycles during an m0 request -> s_req_o stays high for all 5 cycles with stable fields; m0_ack_o pulses only on the ack cycle.
